// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
// Optional PARITY_EN build adds a trailing even-parity bit per word.
package sipo_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    localparam int SIPO_N     = 8;
    localparam int SIPO_CNT_W = $clog2(SIPO_N);

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

endpackage : sipo_pkg

// File: rtl/sipo_if.sv
// Bundle for the receiver: serial bit input side plus the parallel word output side.
// Built with or without PARITY_EN; the signal list is identical in both builds.
interface sipo_if #(parameter int N = 8);
    import sipo_pkg::*;

    // Serial side has no back-pressure: a bit is taken on every edge with sin_valid=1.
    // Word side is valid/ready: p_data is held stable while p_valid=1 and transfers
    // on an edge where p_valid & p_ready; p_valid never drops without a transfer.
    logic         sin_valid;
    logic         sin_bit;
    logic         sin_sync;
    logic         dir_in;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         overrun;
    logic         p_perr;
    state_t       state_dbg;

    modport master (
        output sin_valid, sin_bit, sin_sync, dir_in, p_ready,
        input  p_data, p_valid, overrun, p_perr, state_dbg
    );

    modport slave (
        input  sin_valid, sin_bit, sin_sync, dir_in, p_ready,
        output p_data, p_valid, overrun, p_perr, state_dbg
    );

endinterface : sipo_if

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output register for assembled words and their parity flag.
// A word completing while the entry is full and not being drained is dropped with an overrun pulse.
module sipo_out_buf #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [N-1:0] load_data,
    input  logic         load_perr,
    input  logic         p_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    output logic         p_perr,
    output logic         overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_data  <= '0;
            p_valid <= 1'b0;
            p_perr  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load_valid) begin
                if (p_valid && !p_ready) begin
                    overrun <= 1'b1;
                end else begin
                    p_data  <= load_data;
                    p_perr  <= load_perr;
                    p_valid <= 1'b1;
                end
            end else if (p_valid && p_ready) begin
                // p_data is left as-is; only the flags follow the entry being emptied
                p_valid <= 1'b0;
                p_perr  <= 1'b0;
            end
        end
    end

endmodule : sipo_out_buf

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: shift register, bit counter and framing FSM feeding sipo_out_buf.
// Define PARITY_EN to expect one even-parity bit after every N data bits.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int N = SIPO_N
) (
    input  logic clk,
    input  logic rst,
    sipo_if.slave bus
);

    localparam int CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sreg;
    logic          dir_q;

    state_t        eff_state;
    logic [CW-1:0] eff_cnt;
    logic          dir_use;
    logic          last_bit;
    logic [N-1:0]  shifted;
    logic          done;
    logic [N-1:0]  word;
    logic          perr;

    // sin_sync acts as if the counter were already back at bit 0 for this edge's bit
    always_comb begin
        eff_state = bus.sin_sync ? S_DATA : state;
        eff_cnt   = bus.sin_sync ? '0 : cnt;
        dir_use   = (eff_cnt == '0) ? bus.dir_in : dir_q;
        last_bit  = (eff_cnt == CW'(N - 1));
        shifted   = (dir_use == DIR_LSB_FIRST) ? {bus.sin_bit, sreg[N-1:1]}
                                               : {sreg[N-2:0], bus.sin_bit};
        done      = 1'b0;
        word      = shifted;
        perr      = 1'b0;
`ifdef PARITY_EN
        if (bus.sin_valid && eff_state == S_PARITY) begin
            done = 1'b1;
            word = sreg;
            perr = (^sreg) ^ bus.sin_bit;
        end
`else
        if (bus.sin_valid && eff_state == S_DATA && last_bit) begin
            done = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DATA;
            cnt   <= '0;
            sreg  <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else begin
            if (bus.sin_sync) begin
                cnt   <= '0;
                state <= S_DATA;
            end
            if (bus.sin_valid) begin
                if (eff_state == S_PARITY) begin
                    state <= S_DATA;
                    cnt   <= '0;
                end else begin
                    sreg <= shifted;
                    if (eff_cnt == '0) begin
                        dir_q <= bus.dir_in;
                    end
                    if (last_bit) begin
                        cnt <= '0;
`ifdef PARITY_EN
                        state <= S_PARITY;
`endif
                    end else begin
                        cnt <= eff_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.state_dbg = state;

    sipo_out_buf #(.N(N)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load_valid (done),
        .load_data  (word),
        .load_perr  (perr),
        .p_ready    (bus.p_ready),
        .p_data     (bus.p_data),
        .p_valid    (bus.p_valid),
        .p_perr     (bus.p_perr),
        .overrun    (bus.overrun)
    );

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (N=8); follows the PARITY_EN setting of the build.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_if #(.N(N)) bus ();

  sipo_deserializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_mem [256];
  int got_cnt  = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;

  // Records every handshake, overrun pulse and p_perr cycle as seen just before each edge
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.p_valid && bus.p_ready) begin
        got_mem[got_cnt] <= bus.p_data;
        got_cnt <= got_cnt + 1;
      end
      if (bus.overrun) ovr_cnt <= ovr_cnt + 1;
      if (bus.p_perr) perr_cnt <= perr_cnt + 1;
    end
  end

  // Sends the first nbits of w in the order dir selects; dir_in is inverted after bit 0
  // so a design that keeps following dir_in mid-word scrambles the result.
  task automatic send_word(input logic [N-1:0] w, input logic dir, input int nbits,
                           input int max_gap, input logic sync_first, input logic par_flip);
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = $urandom_range(max_gap, 0);
      repeat (g) @(negedge clk);
      bus.sin_valid = 1'b1;
      bus.sin_bit   = dir ? w[i] : w[N-1-i];
      bus.dir_in    = (i == 0) ? dir : ~dir;
      bus.sin_sync  = (i == 0) && sync_first;
      @(negedge clk);
      bus.sin_valid = 1'b0;
      bus.sin_sync  = 1'b0;
    end
`ifdef PARITY_EN
    if (nbits == N) begin
      bus.sin_valid = 1'b1;
      bus.sin_bit   = (^w) ^ par_flip;
      @(negedge clk);
      bus.sin_valid = 1'b0;
    end
`else
    if (par_flip && nbits < 0) $display("unused parity flip");
`endif
  endtask

  task automatic consume(input string name);
    bus.p_ready = 1'b1;
    @(negedge clk);
    bus.p_ready = 1'b0;
    checks++; if (bus.p_valid !== 1'b0) begin failures++; $display("FAIL %s_drained p_valid got=%0b exp=0", name, bus.p_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sin_valid = 1'b0; bus.sin_bit = 1'b0; bus.sin_sync = 1'b0;
    bus.dir_in = 1'b0; bus.p_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.p_valid !== 1'b0) begin failures++; $display("FAIL reset_p_valid got=%0b exp=0", bus.p_valid); end
    checks++; if (bus.p_data !== 8'h00) begin failures++; $display("FAIL reset_p_data got=%h exp=00", bus.p_data); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); end
    checks++; if (bus.p_perr !== 1'b0) begin failures++; $display("FAIL reset_p_perr got=%0b exp=0", bus.p_perr); end
    checks++; if (bus.state_dbg !== S_DATA) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, S_DATA); end
  endtask

  task automatic test_msb_first();
    send_word(8'hA5, DIR_MSB_FIRST, N, 0, 1'b0, 1'b0);
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL msb_p_valid got=%0b exp=1", bus.p_valid); end
    checks++; if (bus.p_data !== 8'hA5) begin failures++; $display("FAIL msb_p_data got=%h exp=a5", bus.p_data); end
    consume("msb");
  endtask

  task automatic test_lsb_first();
    send_word(8'h1E, DIR_LSB_FIRST, N, 0, 1'b0, 1'b0);
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL lsb_p_valid got=%0b exp=1", bus.p_valid); end
    checks++; if (bus.p_data !== 8'h1E) begin failures++; $display("FAIL lsb_p_data got=%h exp=1e", bus.p_data); end
    consume("lsb");
    send_word(8'h1E, DIR_LSB_FIRST, N, 3, 1'b0, 1'b0);
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL lsb_gaps_p_valid got=%0b exp=1", bus.p_valid); end
    checks++; if (bus.p_data !== 8'h1E) begin failures++; $display("FAIL lsb_gaps_p_data got=%h exp=1e", bus.p_data); end
    consume("lsb_gaps");
  endtask

  task automatic test_overrun();
    int ovr_base;
    ovr_base = ovr_cnt;
    send_word(8'hA5, DIR_MSB_FIRST, N, 0, 1'b0, 1'b0);
    send_word(8'h3C, DIR_MSB_FIRST, N, 0, 1'b0, 1'b0);
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%0b exp=1", bus.overrun); end
    checks++; if (bus.p_data !== 8'hA5) begin failures++; $display("FAIL ovr_p_data got=%h exp=a5", bus.p_data); end
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL ovr_p_valid got=%0b exp=1", bus.p_valid); end
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_pulse_end got=%0b exp=0", bus.overrun); end
    checks++; if (ovr_cnt - ovr_base !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - ovr_base); end
    consume("ovr");
  endtask

  task automatic test_back_to_back();
    int got_base, ovr_base;
    logic [N-1:0] words [5];
    words = '{8'h5A, 8'hFF, 8'h00, 8'h81, 8'h3C};
    got_base = got_cnt;
    ovr_base = ovr_cnt;
    bus.p_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(words[k]);
      send_word(words[k], k[0], N, 0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    bus.p_ready = 1'b0;
    checks++; if (got_cnt - got_base !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", got_cnt - got_base); end
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      checks++; if (got_mem[got_base + k] !== e) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", k, got_mem[got_base + k], e); end
    end
    checks++; if (ovr_cnt - ovr_base !== 0) begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - ovr_base); end
  endtask

  task automatic test_sync_and_reset();
    send_word(8'h5A, DIR_MSB_FIRST, 3, 0, 1'b0, 1'b0);
    checks++; if (bus.p_valid !== 1'b0) begin failures++; $display("FAIL sync_partial_p_valid got=%0b exp=0", bus.p_valid); end
    send_word(8'hC3, DIR_MSB_FIRST, N, 0, 1'b1, 1'b0);
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL sync_p_valid got=%0b exp=1", bus.p_valid); end
    checks++; if (bus.p_data !== 8'hC3) begin failures++; $display("FAIL sync_p_data got=%h exp=c3", bus.p_data); end
    // Entry left full so the reset below has something to clear
    send_word(8'hFF, DIR_MSB_FIRST, 5, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.p_valid !== 1'b0) begin failures++; $display("FAIL midrst_p_valid got=%0b exp=0", bus.p_valid); end
    checks++; if (bus.p_data !== 8'h00) begin failures++; $display("FAIL midrst_p_data got=%h exp=00", bus.p_data); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%0b exp=0", bus.overrun); end
    send_word(8'hC3, DIR_MSB_FIRST, N, 0, 1'b0, 1'b0);
    checks++; if (bus.p_data !== 8'hC3) begin failures++; $display("FAIL midrst_word got=%h exp=c3", bus.p_data); end
    checks++; if (bus.p_valid !== 1'b1) begin failures++; $display("FAIL midrst_word_valid got=%0b exp=1", bus.p_valid); end
    consume("midrst");
  endtask

  task automatic test_parity();
`ifdef PARITY_EN
    send_word(8'hA5, DIR_MSB_FIRST, N, 0, 1'b0, 1'b0);
    checks++; if (bus.p_data !== 8'hA5) begin failures++; $display("FAIL par_ok_data got=%h exp=a5", bus.p_data); end
    checks++; if (bus.p_perr !== 1'b0) begin failures++; $display("FAIL par_ok_perr got=%0b exp=0", bus.p_perr); end
    consume("par_ok");
    send_word(8'hA5, DIR_MSB_FIRST, N, 0, 1'b0, 1'b1);
    checks++; if (bus.p_data !== 8'hA5) begin failures++; $display("FAIL par_bad_data got=%h exp=a5", bus.p_data); end
    checks++; if (bus.p_perr !== 1'b1) begin failures++; $display("FAIL par_bad_perr got=%0b exp=1", bus.p_perr); end
    consume("par_bad");
    checks++; if (bus.p_perr !== 1'b0) begin failures++; $display("FAIL par_cleared got=%0b exp=0", bus.p_perr); end
`else
    send_word(8'hA5, DIR_MSB_FIRST, N, 0, 1'b0, 1'b1);
    checks++; if (bus.p_data !== 8'hA5) begin failures++; $display("FAIL nopar_data got=%h exp=a5", bus.p_data); end
    checks++; if (bus.p_perr !== 1'b0) begin failures++; $display("FAIL nopar_perr got=%0b exp=0", bus.p_perr); end
    consume("nopar");
    checks++; if (perr_cnt !== 0) begin failures++; $display("FAIL nopar_perr_seen got=%0d exp=0", perr_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_sync_and_reset();
    test_parity();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_deserializer
